// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: sequences ADC power-up, paces periodic CONVST pulses and
// watches the asynchronous active-low EOC pin with a per-conversion timeout.
module adc_conv_sequencer #(
  parameter int unsigned PWRUP_CYC       = 32'd1000,
  parameter int unsigned WAKE_CYC        = 32'd100,
  parameter int unsigned CONVST_LOW_CYC  = 32'd5,
  parameter int unsigned PERIOD_CYC      = 32'd100,
  parameter int unsigned EOC_TIMEOUT_CYC = 32'd50
) (
  input  logic        clk_100M,
  input  logic        Reset,
  input  logic        run_en,
  input  logic        pd_req,
  input  logic        EOC_18,
  output logic        CONVST_out,
  output logic        PD_out,
  output logic        ready,
  output logic        conv_done,
  output logic [15:0] conv_count,
  output logic        timeout_err
);

  localparam logic [15:0] PWRUP_LAST   = 16'(PWRUP_CYC - 32'd1);
  localparam logic [15:0] WAKE_LAST    = 16'(WAKE_CYC - 32'd1);
  localparam logic [15:0] LOW_LAST     = 16'(CONVST_LOW_CYC - 32'd1);
  localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD_CYC - 32'd1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(EOC_TIMEOUT_CYC - 32'd1);

  typedef enum logic [2:0] {
    PWR_OFF  = 3'd0,
    WAKE     = 3'd1,
    IDLE     = 3'd2,
    CONV_LOW = 3'd3,
    WAIT_EOC = 3'd4,
    HOLDOFF  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;
  logic [15:0] per_cnt_r;
  logic [15:0] per_cnt_next_s;
  logic        eoc_meta_r;
  logic        eoc_sync_r;
  logic        eoc_prev_r;
  logic        eoc_fall_s;
  logic        done_s;
  logic        timeout_s;

  assign eoc_fall_s = eoc_prev_r & ~eoc_sync_r;

  // EOC synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      eoc_meta_r <= 1'b1;
      eoc_sync_r <= 1'b1;
      eoc_prev_r <= 1'b1;
    end else begin
      eoc_meta_r <= EOC_18;
      eoc_sync_r <= eoc_meta_r;
      eoc_prev_r <= eoc_sync_r;
    end
  end

  // Next-state, event strobes and counter updates
  always_comb begin
    state_next_s = state_r;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      PWR_OFF: begin
        if (!pd_req && (cnt_r == PWRUP_LAST)) state_next_s = WAKE;
        else                                  state_next_s = PWR_OFF;
      end
      WAKE: begin
        if (cnt_r == WAKE_LAST) state_next_s = IDLE;
        else                    state_next_s = WAKE;
      end
      IDLE: begin
        if (pd_req)      state_next_s = PWR_OFF;
        else if (run_en) state_next_s = CONV_LOW;
        else             state_next_s = IDLE;
      end
      CONV_LOW: begin
        if (cnt_r == LOW_LAST) state_next_s = WAIT_EOC;
        else                   state_next_s = CONV_LOW;
      end
      WAIT_EOC: begin
        // a real edge wins over a timeout landing in the same cycle
        if (eoc_fall_s) begin
          done_s       = 1'b1;
          state_next_s = HOLDOFF;
        end else if (cnt_r == TIMEOUT_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = HOLDOFF;
        end else begin
          state_next_s = WAIT_EOC;
        end
      end
      HOLDOFF: begin
        if (per_cnt_r == PERIOD_LAST) begin
          if (pd_req)      state_next_s = PWR_OFF;
          else if (run_en) state_next_s = CONV_LOW;
          else             state_next_s = IDLE;
        end else begin
          state_next_s = HOLDOFF;
        end
      end
      default: state_next_s = PWR_OFF;
    endcase

    // pd_req held in PWR_OFF keeps the power-up wait pinned at zero
    if ((state_next_s != state_r) || ((state_r == PWR_OFF) && pd_req)) cnt_next_s = 16'd0;
    else if (cnt_r != 16'hFFFF)                                          cnt_next_s = cnt_r + 16'd1;
    else                                                                 cnt_next_s = cnt_r;

    if ((state_next_s == CONV_LOW) && (state_r != CONV_LOW)) per_cnt_next_s = 16'd0;
    else if (per_cnt_r < PERIOD_LAST)                        per_cnt_next_s = per_cnt_r + 16'd1;
    else                                                     per_cnt_next_s = per_cnt_r;
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_r     <= PWR_OFF;
      cnt_r       <= 16'd0;
      per_cnt_r   <= 16'd0;
      CONVST_out  <= 1'b1;
      PD_out      <= 1'b0;
      ready       <= 1'b0;
      conv_done   <= 1'b0;
      conv_count  <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      per_cnt_r   <= per_cnt_next_s;
      CONVST_out  <= (state_next_s != CONV_LOW);
      PD_out      <= (state_next_s != PWR_OFF);
      ready       <= (state_next_s == IDLE);
      conv_done   <= done_s;
      conv_count  <= conv_count + {15'd0, done_s};
      timeout_err <= timeout_err | timeout_s;
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a simple ADC EOC response model.
`timescale 1ns/1ps
module tb_adc_conv_sequencer;

  logic        clk_100M = 1'b0;
  logic        Reset;
  logic        run_en;
  logic        pd_req;
  logic        EOC_18;
  logic        CONVST_out;
  logic        PD_out;
  logic        ready;
  logic        conv_done;
  logic [15:0] conv_count;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit eoc_mode = 1'b0;

  adc_conv_sequencer dut (
    .clk_100M    (clk_100M),
    .Reset       (Reset),
    .run_en      (run_en),
    .pd_req      (pd_req),
    .EOC_18      (EOC_18),
    .CONVST_out  (CONVST_out),
    .PD_out      (PD_out),
    .ready       (ready),
    .conv_done   (conv_done),
    .conv_count  (conv_count),
    .timeout_err (timeout_err)
  );

  always #5 clk_100M = ~clk_100M;

  // ADC model: EOC goes low 20 cycles after CONVST rises, high again 10 later
  initial begin : eoc_model
    int  k;
    logic prev;
    EOC_18 = 1'b1;
    prev   = 1'b1;
    k      = -1;
    forever begin
      @(posedge clk_100M);
      #2;
      if (prev === 1'b0 && CONVST_out === 1'b1 && eoc_mode) k = 0;
      else if (k >= 0) k++;
      if (k == 20 && eoc_mode) EOC_18 = 1'b0;
      if (k == 30) begin
        EOC_18 = 1'b1;
        k = -1;
      end
      prev = CONVST_out;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, got cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_100M);
    #1;
    cyc++;
  endtask

  task automatic wait_fall(input int lim, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (CONVST_out === 1'b0) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic low_width(output int w);
    w = 0;
    while (CONVST_out === 1'b0 && w < 20) begin
      w++;
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; run_en = 1'b0; pd_req = 1'b0;
    tick(); tick(); tick();
    total++; if (CONVST_out !== 1'b1) begin bad++; $display("FAIL reset_convst got=%b want=1", CONVST_out); end
    total++; if (PD_out !== 1'b0) begin bad++; $display("FAIL reset_pd got=%b want=0", PD_out); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (conv_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", conv_done); end
    total++; if (conv_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h want=0000", conv_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    Reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_powerup();
    bit cv_hi = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (CONVST_out !== 1'b1) cv_hi = 1'b0;
      if (i == 999) begin total++; if (PD_out !== 1'b0) begin bad++; $display("FAIL pwrup_pd_999 got=%b want=0", PD_out); end end
      if (i == 1000) begin total++; if (PD_out !== 1'b1) begin bad++; $display("FAIL pwrup_pd_1000 got=%b want=1", PD_out); end end
      if (i == 1099) begin total++; if (ready !== 1'b0) begin bad++; $display("FAIL pwrup_ready_1099 got=%b want=0", ready); end end
      if (i == 1100) begin total++; if (ready !== 1'b1) begin bad++; $display("FAIL pwrup_ready_1100 got=%b want=1", ready); end end
    end
    total++; if (cv_hi !== 1'b1) begin bad++; $display("FAIL pwrup_convst_idle got=%b want=1", cv_hi); end
  endtask

  task automatic test_timeout();
    bit ok;
    int at, prev_at, w;
    bit seen_done = 1'b0;
    eoc_mode = 1'b0;
    run_en   = 1'b1;
    prev_at  = -1;
    for (int p = 0; p < 3; p++) begin
      wait_fall(200, ok, at);
      total++; if (!ok) begin bad++; $display("FAIL to_fall_seen got=none want=fall p=%0d", p); end
      if (p > 0) begin total++; if (at - prev_at != 100) begin bad++; $display("FAIL to_period got=%0d want=100", at - prev_at); end end
      prev_at = at;
      low_width(w);
      total++; if (w != 5) begin bad++; $display("FAIL to_low_width got=%0d want=5", w); end
      for (int t = 1; t <= 50; t++) begin
        tick();
        if (conv_done === 1'b1) seen_done = 1'b1;
        if (p == 0 && t == 49) begin total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b want=0", timeout_err); end end
        if (t == 50) begin total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b want=1", timeout_err); end end
      end
      total++; if (conv_count !== 16'h0000) begin bad++; $display("FAIL to_count got=%h want=0000", conv_count); end
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL to_no_done got=%b want=0", seen_done); end
    eoc_mode = 1'b1;
  endtask

  task automatic test_conversions();
    bit ok;
    int at, prev_at, w, d;
    prev_at = -1;
    for (int p = 0; p < 10; p++) begin
      wait_fall(200, ok, at);
      total++; if (!ok) begin bad++; $display("FAIL cv_fall_seen got=none want=fall p=%0d", p); end
      if (p > 0) begin total++; if (at - prev_at != 100) begin bad++; $display("FAIL cv_period got=%0d want=100", at - prev_at); end end
      prev_at = at;
      low_width(w);
      total++; if (w != 5) begin bad++; $display("FAIL cv_low_width got=%0d want=5", w); end
      d = 0;
      while (conv_done !== 1'b1 && d < 40) begin tick(); d++; end
      total++; if (d < 22 || d > 23) begin bad++; $display("FAIL cv_done_lat got=%0d want=22..23", d); end
      total++; if (conv_count !== 16'(p + 1)) begin bad++; $display("FAIL cv_count got=%0d want=%0d", conv_count, p + 1); end
      tick();
      total++; if (conv_done !== 1'b0) begin bad++; $display("FAIL cv_done_width got=%b want=0", conv_done); end
    end
    total++; if (conv_count !== 16'd10) begin bad++; $display("FAIL cv_count_10 got=%0d want=10", conv_count); end
  endtask

  task automatic test_pd_during_conv();
    bit ok;
    int at, w, d, pd_at;
    bit cv_hi = 1'b1;
    wait_fall(200, ok, at);
    total++; if (!ok) begin bad++; $display("FAIL pd_fall_seen got=none want=fall"); end
    low_width(w);
    pd_req = 1'b1;
    run_en = 1'b0;
    d = 0;
    while (conv_done !== 1'b1 && d < 40) begin tick(); d++; end
    total++; if (conv_done !== 1'b1) begin bad++; $display("FAIL pd_conv_done got=%b want=1", conv_done); end
    total++; if (conv_count !== 16'd11) begin bad++; $display("FAIL pd_count got=%0d want=11", conv_count); end
    pd_at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (CONVST_out !== 1'b1) cv_hi = 1'b0;
      if (PD_out === 1'b0) begin pd_at = cyc; break; end
    end
    total++; if (pd_at - at != 100) begin bad++; $display("FAIL pd_drop_time got=%0d want=100", pd_at - at); end
    total++; if (cv_hi !== 1'b1) begin bad++; $display("FAIL pd_no_new_conv got=%b want=1", cv_hi); end
    for (int i = 0; i < 10; i++) tick();
    pd_req = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (i == 999) begin total++; if (PD_out !== 1'b0) begin bad++; $display("FAIL pd_rel_pd_999 got=%b want=0", PD_out); end end
      if (i == 1000) begin total++; if (PD_out !== 1'b1) begin bad++; $display("FAIL pd_rel_pd_1000 got=%b want=1", PD_out); end end
      if (i == 1099) begin total++; if (ready !== 1'b0) begin bad++; $display("FAIL pd_rel_ready_1099 got=%b want=0", ready); end end
      if (i == 1100) begin total++; if (ready !== 1'b1) begin bad++; $display("FAIL pd_rel_ready_1100 got=%b want=1", ready); end end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int at, d;
    logic [15:0] want [2];
    want[0] = 16'hFFFF;
    want[1] = 16'h0000;
    force dut.conv_count = 16'hFFFE;
    tick();
    release dut.conv_count;
    tick();
    total++; if (conv_count !== 16'hFFFE) begin bad++; $display("FAIL wrap_preload got=%h want=fffe", conv_count); end
    run_en = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_fall(200, ok, at);
      d = 0;
      while (conv_done !== 1'b1 && d < 60) begin tick(); d++; end
      total++; if (conv_count !== want[n]) begin bad++; $display("FAIL wrap_count got=%h want=%h", conv_count, want[n]); end
    end
  endtask

  task automatic test_reset_mid_conv();
    bit ok;
    int at;
    wait_fall(200, ok, at);
    tick(); tick();
    total++; if (CONVST_out !== 1'b0) begin bad++; $display("FAIL rst_pre_convst got=%b want=0", CONVST_out); end
    Reset = 1'b0;
    #1;
    total++; if (CONVST_out !== 1'b1) begin bad++; $display("FAIL rst_mid_convst got=%b want=1", CONVST_out); end
    total++; if (PD_out !== 1'b0) begin bad++; $display("FAIL rst_mid_pd got=%b want=0", PD_out); end
    total++; if (conv_count !== 16'h0000) begin bad++; $display("FAIL rst_mid_count got=%h want=0000", conv_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_mid_timeout got=%b want=0", timeout_err); end
    tick(); tick(); tick();
    Reset  = 1'b1;
    run_en = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 999) begin total++; if (PD_out !== 1'b0) begin bad++; $display("FAIL rst_rel_pd_999 got=%b want=0", PD_out); end end
      if (i == 1000) begin total++; if (PD_out !== 1'b1) begin bad++; $display("FAIL rst_rel_pd_1000 got=%b want=1", PD_out); end end
    end
  endtask

  initial begin : main
    test_reset();
    test_powerup();
    test_timeout();
    test_conversions();
    test_pd_during_conv();
    test_wrap();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
Upstream timing stage for the 8-bit parallel ADC read-out controller. It drives that controller's CONVST_in and PD_in inputs, and paces the ADC from the 100 MHz fabric clock. It sequences ADC power-up, issues periodic conversion-start pulses, and watches the ADC end-of-conversion pin with a timeout. It reports conversion events and status to software-facing logic.

Parameters:
PWRUP_CYC, 1000, cycles PD held low after reset release or power-down exit (10 us)
WAKE_CYC, 100, cycles after PD rises before first conversion is allowed (1 us)
CONVST_LOW_CYC, 5, CONVST low pulse width in cycles (50 ns)
PERIOD_CYC, 100, conversion period in cycles, measured CONVST fall to CONVST fall (1 MSPS)
EOC_TIMEOUT_CYC, 50, max cycles from CONVST rise to detected EOC low
Constraints: all parameters 1..65535; PERIOD_CYC >= CONVST_LOW_CYC + EOC_TIMEOUT_CYC + 20 (leaves room for the 16-cycle read-out).

Ports:
clk_100M  in  1  100 MHz clock
Reset  in  1  asynchronous, active-low reset
run_en  in  1  level; 1 = convert continuously at PERIOD_CYC
pd_req  in  1  level; 1 = request ADC power-down
EOC_18  in  1  ADC end-of-conversion pin (active low, asynchronous)
CONVST_out  out  1  to read-out controller CONVST_in; idle high
PD_out  out  1  to read-out controller PD_in; 0 = ADC powered down
ready  out  1  1 while in IDLE (ADC powered and awake)
conv_done  out  1  one-cycle pulse on detected EOC falling edge
conv_count  out  16  conversions completed, wraps 0xFFFF->0x0000
timeout_err  out  1  sticky flag; cleared only by Reset

Behaviour:
- All outputs registered. Reset values: CONVST_out=1, PD_out=0, ready=0, conv_done=0, conv_count=0, timeout_err=0. FSM resets to PWR_OFF.
- EOC_18 passes through a 2-flop synchronizer (both flops reset to 1). Falling edge = previous synchronized value 1 and current value 0. Detection latency is 2-3 cycles.
- A single 16-bit state counter clears on every state entry. A separate 16-bit period counter clears when CONV_LOW is entered and saturates at PERIOD_CYC-1.
- PWR_OFF: PD=0, CONVST=1. Stays until pd_req=0 and the counter reaches PWRUP_CYC-1, then goes to WAKE.
- WAKE: PD=1. After WAKE_CYC cycles, goes to IDLE.
- IDLE: ready=1. If pd_req=1, goes to PWR_OFF (pd_req has priority over run_en). Otherwise, if run_en=1, goes to CONV_LOW.
- CONV_LOW: CONVST=0 for exactly CONVST_LOW_CYC cycles, then goes to WAIT_EOC.
- WAIT_EOC: CONVST=1.
  - On EOC falling edge: conv_done pulses for 1 cycle, conv_count increments, FSM goes to HOLDOFF.
  - If EOC_TIMEOUT_CYC cycles pass with no edge: timeout_err is set, no count or pulse, FSM goes to HOLDOFF.
- HOLDOFF: CONVST=1. Waits until the period counter reaches PERIOD_CYC-1.
  - If pd_req=1, goes to PWR_OFF.
  - Else if run_en=1, goes to CONV_LOW, so CONVST falls exactly PERIOD_CYC cycles after the previous fall.
  - Else goes to IDLE.
- A conversion in progress (CONV_LOW or WAIT_EOC) is never aborted by run_en or pd_req. Only Reset aborts it.
- pd_req falling while in PWR_OFF restarts the full PWRUP_CYC wait from 0.
- EOC edges outside WAIT_EOC are ignored.
- Reset mid-operation immediately forces CONVST=1 and PD=0, clears conv_count and timeout_err, and restarts the full power-up sequence.

Test Plan:
- Release Reset at t=0 with run_en=0 and pd_req=0. PD_out rises at cycle 1000, ready rises at cycle 1100, and CONVST_out stays 1 throughout.
- Set run_en=1 in IDLE. The bench model pulls EOC low 20 cycles after CONVST rises.
  - CONVST is low for exactly 5 cycles each time; successive falls are 100 cycles apart.
  - conv_done fires 2-3 cycles after EOC falls.
  - conv_count reads 10 after 10 periods.
- Bench model never asserts EOC. timeout_err sets 50 cycles after CONVST rises, conv_count stays 0, and CONVST still falls every 100 cycles.
- Assert pd_req during WAIT_EOC. The conversion completes with conv_count +1, then PD_out drops. Release pd_req: PD_out rises 1000 cycles later and ready 100 cycles after that.
- Preload conv_count to 0xFFFE by running 65534 conversions (or force in simulation). Two more EOCs give 0xFFFF, then 0x0000.
- Pulse Reset low for 3 cycles in the middle of CONV_LOW. CONVST_out=1, PD_out=0 and conv_count=0 within the reset, and PD_out rises again 1000 cycles after release.
